axis_merge_rr: RTL and testbench

//  Two-input AXI-Stream merger with round-robin, burst-granular arbitration; re-joins the two

---
 rtl/axis_merge_rr_pkg.sv | 18 +
 rtl/axis_merge_rr_reg_slice.sv | 42 ++++
 rtl/axis_merge_rr.sv | 100 ++++++++++
 tb/tb_axis_merge_rr.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/axis_merge_rr_pkg.sv
// Shared definitions for the two-input round-robin AXI-Stream merger.
package axis_merge_rr_pkg;

  localparam logic PORT_0 = 1'b0;
  localparam logic PORT_1 = 1'b1;

  // Port picked by the arbiter in a given cycle; valid=0 means nobody is served.
  typedef struct packed {
    logic valid;
    logic id;
  } sel_t;

  // Width of a counter that must hold values 0..burst_len inclusive.
  function automatic int cnt_width(input int burst_len);
    return (burst_len < 1) ? 1 : $clog2(burst_len + 1);
  endfunction

endpackage

// File: rtl/axis_merge_rr_reg_slice.sv
// Single output register stage carrying valid, data and source id.
module axis_reg_slice #(
  parameter int DATA_WD = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_valid,
  input  logic [DATA_WD-1:0] i_data,
  input  logic               i_id,
  input  logic               i_ready,
  output logic               o_valid,
  output logic [DATA_WD-1:0] o_data,
  output logic               o_id,
  output logic               o_load
);

  logic               r_valid;
  logic [DATA_WD-1:0] r_data;
  logic               r_id;

  // The register may take a new beat whenever it is empty or being drained.
  assign o_load = !r_valid | i_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_id    <= 1'b0;
    end else if (o_load) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_data <= i_data;
        r_id   <= i_id;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_id    = r_id;

endmodule

// File: rtl/axis_merge_rr.sv
// Two-input AXI-Stream merger with burst-granular round-robin arbitration.
// Handshake: a beat moves on a port in any cycle where its tvalid and tready are both high.
module axis_merge_rr
  import axis_merge_rr_pkg::*;
#(
  parameter int DATA_WD   = 64,
  parameter int BURST_LEN = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               merge_enable,
  input  logic               s00_axis_tvalid,
  input  logic [DATA_WD-1:0] s00_axis_tdata,
  output logic               s00_axis_tready,
  input  logic               s01_axis_tvalid,
  input  logic [DATA_WD-1:0] s01_axis_tdata,
  output logic               s01_axis_tready,
  output logic               m_axis_tvalid,
  output logic [DATA_WD-1:0] m_axis_tdata,
  output logic               m_axis_tid,
  input  logic               m_axis_tready,
  output logic               grant
);

  localparam int             CW      = cnt_width(BURST_LEN);
  localparam logic [CW-1:0]  CNT_MAX = CW'(BURST_LEN);
  localparam logic [CW-1:0]  CNT_ONE = CW'(1);

  logic               r_grant;
  logic [CW-1:0]      r_cnt;

  logic               w_load;
  logic               w_v0;
  logic               w_v1;
  logic               w_own_v;
  logic               w_oth_v;
  logic               w_restart;
  logic               w_accept;
  sel_t               w_sel;
  logic [DATA_WD-1:0] w_sel_data;

  assign w_v0    = s00_axis_tvalid;
  assign w_v1    = s01_axis_tvalid & merge_enable;
  assign w_own_v = (r_grant == PORT_1) ? w_v1 : w_v0;
  assign w_oth_v = (r_grant == PORT_1) ? w_v0 : w_v1;

  // Owner keeps the stream until its burst is spent; a lone owner may start a fresh burst.
  always_comb begin
    w_sel     = '0;
    w_restart = 1'b0;
    if (w_own_v && (r_cnt < CNT_MAX)) begin
      w_sel.valid = 1'b1;
      w_sel.id    = r_grant;
    end else if (w_oth_v) begin
      w_sel.valid = 1'b1;
      w_sel.id    = ~r_grant;
    end else if (w_own_v) begin
      w_sel.valid = 1'b1;
      w_sel.id    = r_grant;
      w_restart   = 1'b1;
    end
  end

  assign w_accept        = w_load & w_sel.valid;
  assign s00_axis_tready = w_accept & (w_sel.id == PORT_0);
  assign s01_axis_tready = w_accept & (w_sel.id == PORT_1);
  assign w_sel_data      = (w_sel.id == PORT_1) ? s01_axis_tdata : s00_axis_tdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant <= PORT_0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      if (w_sel.id == r_grant) begin
        r_cnt <= w_restart ? CNT_ONE : (r_cnt + CNT_ONE);
      end else begin
        r_grant <= w_sel.id;
        r_cnt   <= CNT_ONE;
      end
    end
  end

  assign grant = r_grant;

  axis_reg_slice #(
    .DATA_WD (DATA_WD)
  ) u_out_reg (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_accept),
    .i_data  (w_sel_data),
    .i_id    (w_sel.id),
    .i_ready (m_axis_tready),
    .o_valid (m_axis_tvalid),
    .o_data  (m_axis_tdata),
    .o_id    (m_axis_tid),
    .o_load  (w_load)
  );

endmodule

// File: tb/tb_axis_merge_rr.sv
// Randomised bench for axis_merge_rr: per-cycle arbitration reference plus an output scoreboard.
module tb_axis_merge_rr;

  localparam int DATA_WD   = 64;
  localparam int BURST_LEN = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic               merge_enable = 1'b1;
  logic               s00_axis_tvalid = 1'b0;
  logic [DATA_WD-1:0] s00_axis_tdata = '0;
  logic               s00_axis_tready;
  logic               s01_axis_tvalid = 1'b0;
  logic [DATA_WD-1:0] s01_axis_tdata = '0;
  logic               s01_axis_tready;
  logic               m_axis_tvalid;
  logic [DATA_WD-1:0] m_axis_tdata;
  logic               m_axis_tid;
  logic               m_axis_tready = 1'b0;
  logic               grant;

  axis_merge_rr #(
    .DATA_WD   (DATA_WD),
    .BURST_LEN (BURST_LEN)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .merge_enable    (merge_enable),
    .s00_axis_tvalid (s00_axis_tvalid),
    .s00_axis_tdata  (s00_axis_tdata),
    .s00_axis_tready (s00_axis_tready),
    .s01_axis_tvalid (s01_axis_tvalid),
    .s01_axis_tdata  (s01_axis_tdata),
    .s01_axis_tready (s01_axis_tready),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tid      (m_axis_tid),
    .m_axis_tready   (m_axis_tready),
    .grant           (grant)
  );

  // scoreboard: {source id, data} in the order beats must leave the merger
  logic [DATA_WD:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [DATA_WD:0] act, input logic [DATA_WD:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // reference: which port owns the stream and how many beats it has sent in its current run
  logic             pend [2];
  logic [DATA_WD-1:0] pdata [2];
  int               seq [2];
  int               mdl_owner = 0;
  int               mdl_run   = 0;
  logic             mdl_ovalid = 1'b0;

  task automatic new_beat(input int p);
    pend[p]  = 1'b1;
    pdata[p] = (p == 0) ? DATA_WD'(64'h10 + 64'(seq[0])) : DATA_WD'(64'h1_0000_0000 + 64'(seq[1]));
    seq[p]++;
  endtask

  task automatic drive_ports();
    s00_axis_tvalid = pend[0];
    s00_axis_tdata  = pend[0] ? pdata[0] : '0;
    s01_axis_tvalid = pend[1];
    s01_axis_tdata  = pend[1] ? pdata[1] : '0;
  endtask

  // one clock: entered and left at a falling edge
  task automatic cycle(input int rdy_pct, input int en_pct, input int v0_pct, input int v1_pct);
    logic load, want0, want1, accept;
    int   sel, other;
    m_axis_tready = ($urandom_range(99) < rdy_pct);
    merge_enable  = ($urandom_range(99) < en_pct);
    if (!pend[0] && ($urandom_range(99) < v0_pct)) new_beat(0);
    if (!pend[1] && ($urandom_range(99) < v1_pct)) new_beat(1);
    drive_ports();
    #1;
    load   = !mdl_ovalid || m_axis_tready;
    want0  = pend[0];
    want1  = pend[1] && merge_enable;
    other  = 1 - mdl_owner;
    sel    = -1;
    if (((mdl_owner == 0) ? want0 : want1) && mdl_run < BURST_LEN) sel = mdl_owner;
    else if ((other == 0) ? want0 : want1) sel = other;
    else if ((mdl_owner == 0) ? want0 : want1) sel = mdl_owner;
    accept = load && (sel >= 0);
    chk("s00_tready", {64'h0, s00_axis_tready}, {64'h0, accept && sel == 0});
    chk("s01_tready", {64'h0, s01_axis_tready}, {64'h0, accept && sel == 1});
    chk("m_tvalid",   {64'h0, m_axis_tvalid},   {64'h0, mdl_ovalid});
    chk("grant",      {64'h0, grant},           {64'h0, mdl_owner[0]});
    @(posedge clk);
    if (accept) begin
      exp_q.push_back({sel[0], pdata[sel]});
      pend[sel] = 1'b0;
      if (sel == mdl_owner) mdl_run = (mdl_run < BURST_LEN) ? mdl_run + 1 : 1;
      else begin
        mdl_owner = sel;
        mdl_run   = 1;
      end
      mdl_ovalid = 1'b1;
    end else if (load) begin
      mdl_ovalid = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    drive_ports();
    m_axis_tready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    exp_q.delete();
    mdl_owner  = 0;
    mdl_run    = 0;
    mdl_ovalid = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst_tvalid", {64'h0, m_axis_tvalid}, '0);
    chk("rst_tdata",  {1'b0, m_axis_tdata},   '0);
    chk("rst_tid",    {64'h0, m_axis_tid},    '0);
    chk("rst_grant",  {64'h0, grant},         '0);
  endtask

  // monitor: pops on every output handshake, and checks stalled beats hold still
  logic             prev_stall = 1'b0;
  logic [DATA_WD+1:0] prev_out = '0;
  initial begin
    logic [DATA_WD:0] exp;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall)
          chk("stall_hold", {m_axis_tid, m_axis_tdata}, prev_out[DATA_WD:0]);
        if (m_axis_tvalid && m_axis_tready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", {m_axis_tid, m_axis_tdata}, '1);
          end else begin
            exp = exp_q.pop_front();
            chk("out_beat", {m_axis_tid, m_axis_tdata}, exp);
          end
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_out   = {m_axis_tvalid, m_axis_tid, m_axis_tdata};
      end
    end
  end

  initial begin
    seq[0] = 0;
    seq[1] = 0;
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    @(negedge clk);
    apply_reset();
    // port 0 alone, full rate
    for (int i = 0; i < 7; i++) cycle(100, 100, (i < 6) ? 100 : 0, 0);
    // contention: bursts of BURST_LEN alternate
    for (int i = 0; i < 40; i++) cycle(100, 100, 100, 100);
    for (int i = 0; i < 80; i++) cycle(70, 100, 60, 60);
    // downstream stall with both ports waiting
    for (int i = 0; i < 5; i++) cycle(0, 100, 100, 100);
    for (int i = 0; i < 10; i++) cycle(100, 100, 100, 100);
    // port 1 masked, then re-enabled
    for (int i = 0; i < 30; i++) cycle(100, 0, 80, 100);
    for (int i = 0; i < 30; i++) cycle(100, 100, 100, 100);
    for (int i = 0; i < 150; i++) cycle(60, 80, 50, 50);
    // reset mid-transfer with a beat held on the output
    for (int i = 0; i < 3; i++) cycle(100, 100, 100, 0);
    cycle(0, 100, 100, 0);
    chk("pre_rst_valid", {64'h0, m_axis_tvalid}, {64'h0, 1'b1});
    apply_reset();
    cycle(100, 100, 100, 100);
    chk("post_rst_first", {64'h0, m_axis_tid}, '0);
    for (int i = 0; i < 200; i++) cycle($urandom_range(30, 100), 80, 60, 60);
    // drain
    for (int i = 0; i < 6; i++) cycle(100, 100, 0, 0);
    @(negedge clk);
    chk("queue_empty", DATA_WD'(exp_q.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
